// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default operand width
// for the multicycle ALU and its iterative multiply/divide datapath.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_MULU = 4'd6;
  localparam logic [3:0] OP_DIVU = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// One-bit-per-cycle unsigned shift-add multiplier and restoring divider
// sharing a single shift register pair and a down-counting step timer.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH);

  logic             active;
  logic             is_div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] md, hi_q, lo_q, hi_step, lo_step, rem_sub;
  logic [WIDTH:0]   add_ext, shifted;
  logic             ge;

  assign add_ext = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md} : '0);
  assign shifted = {hi_q, lo_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, md};
  // Remainder stays below the divisor, so the low word of the difference is exact;
  // a zero divisor makes every step subtract, yielding all-ones quotient, remainder = a.
  assign rem_sub = shifted[WIDTH-1:0] - md;

  always_comb begin
    hi_step = hi_q;
    lo_step = lo_q;
    if (is_div) begin
      hi_step = ge ? rem_sub : shifted[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_step = add_ext[WIDTH:1];
      lo_step = {add_ext[0], lo_q[WIDTH-1:1]};
    end
  end

  // Final step is presented combinationally so the caller can register it on the last edge.
  assign done = active && (cnt == '0);
  assign lo   = lo_step;
  assign hi   = hi_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      md     <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start) begin
      active <= 1'b1;
      is_div <= op_div;
      cnt    <= CW'(WIDTH - 1);
      md     <= op_div ? b : a;
      hi_q   <= '0;
      lo_q   <= op_div ? a : b;
    end else if (active) begin
      hi_q <= hi_step;
      lo_q <= lo_step;
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith ops inline, mulu/divu via muldiv_seq.
//   state   | meaning
//   IDLE    | waiting for an accepted start
//   EXEC    | single-cycle op; results registered on the next edge
//   ITER    | mulu/divu stepping one bit per cycle in muldiv_seq
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);
  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, diff, md_lo, md_hi, res_nxt, hi_nxt;
  logic [WIDTH:0]   sum_ext;
  logic             accept, is_iter, md_start, md_done, load_out;
  logic             cout_nxt, ovf_nxt, dbz_nxt;

  assign is_iter  = (control == OP_MULU) || (control == OP_DIVU);
  assign accept   = (state == ST_IDLE) && !busy && start;
  assign md_start = accept && is_iter;
  assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
  assign diff     = a_q - b_q;

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op_div (control == OP_DIVU),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    res_nxt   = '0;
    hi_nxt    = '0;
    cout_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    dbz_nxt   = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_iter ? ST_ITER : ST_EXEC;
      ST_EXEC: begin
        state_nxt = ST_IDLE;
        load_out  = 1'b1;
        case (op_q)
          OP_AND: res_nxt = a_q & b_q;
          OP_OR:  res_nxt = a_q | b_q;
          OP_NOR: res_nxt = ~(a_q | b_q);
          OP_ADD: begin
            res_nxt  = sum_ext[WIDTH-1:0];
            cout_nxt = sum_ext[WIDTH];
            ovf_nxt  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
          end
          OP_SUB: begin
            res_nxt  = diff;
            cout_nxt = a_q >= b_q;
            ovf_nxt  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
          end
          OP_SLT:  res_nxt = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
          default: res_nxt = '0;
        endcase
      end
      ST_ITER: if (md_done) begin
        state_nxt = ST_IDLE;
        load_out  = 1'b1;
        res_nxt   = md_lo;
        hi_nxt    = md_hi;
        if (op_q == OP_MULU) ovf_nxt = (md_hi != '0);
        else                 dbz_nxt = (b_q == '0);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // busy lags the FSM by one edge: high from the first non-idle cycle through the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      cout        <= 1'b0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      busy <= (state != ST_IDLE);
      done <= load_out;
      if (accept) begin
        op_q <= control;
        a_q  <= a;
        b_q  <= b;
      end
      if (load_out) begin
        result      <= res_nxt;
        result_hi   <= hi_nxt;
        cout        <= cout_nxt;
        zero        <= (res_nxt == '0);
        overflow    <= ovf_nxt;
        div_by_zero <= dbz_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, start8;
  logic [3:0]  ctl32, ctl8;
  logic [31:0] a32, b32, res32, hi32;
  logic [7:0]  a8, b8, res8, hi8;
  logic        busy32, done32, cout32, zero32, ovf32, dbz32;
  logic        busy8, done8, cout8, zero8, ovf8, dbz8;

  int n_vec = 0;
  int n_bad = 0;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .control(ctl32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .result_hi(hi32),
    .cout(cout32), .zero(zero32), .overflow(ovf32), .div_by_zero(dbz32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .control(ctl8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
    .cout(cout8), .zero(zero8), .overflow(ovf8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is seen at the following posedge (edge N).
  task automatic issue(input bit w8, input logic [3:0] ctl, input logic [63:0] av, input logic [63:0] bv);
    if (w8) begin start8 = 1'b1; ctl8 = ctl; a8 = av[7:0]; b8 = bv[7:0]; end
    else    begin start32 = 1'b1; ctl32 = ctl; a32 = av[31:0]; b32 = bv[31:0]; end
    @(posedge clk);
    #1;
    if (w8) begin start8 = 1'b0; ctl8 = OP_SUB; a8 = ~av[7:0]; b8 = ~bv[7:0]; end
    else    begin start32 = 1'b0; ctl32 = OP_SUB; a32 = ~av[31:0]; b32 = ~bv[31:0]; end
  endtask

  // k counts edges after N; lat = k of the cycle where done is seen.
  task automatic wait_done(input bit w8, output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int k = 0; k <= 80; k++) begin
      @(negedge clk);
      if (w8 ? busy8 : busy32) busy_cyc++;
      if (w8 ? done8 : done32) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic vec(input string tag, input bit w8, input logic [3:0] ctl,
                     input logic [63:0] av, input logic [63:0] bv,
                     input logic [63:0] r, input logic [63:0] h,
                     input bit c, input bit z, input bit o, input bit d, input int lat_exp);
    int lat, bcyc;
    logic [63:0] r_obs;
    @(negedge clk);
    issue(w8, ctl, av, bv);
    wait_done(w8, lat, bcyc);
    check({tag, "/latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "/busy_cycles"}, 64'(bcyc), 64'(lat_exp));
    r_obs = w8 ? {56'd0, res8} : {32'd0, res32};
    check({tag, "/result"}, r_obs, r);
    check({tag, "/result_hi"}, w8 ? {56'd0, hi8} : {32'd0, hi32}, h);
    check({tag, "/cout"}, 64'(w8 ? cout8 : cout32), 64'(c));
    check({tag, "/zero"}, 64'(w8 ? zero8 : zero32), 64'(z));
    check({tag, "/overflow"}, 64'(w8 ? ovf8 : ovf32), 64'(o));
    check({tag, "/div_by_zero"}, 64'(w8 ? dbz8 : dbz32), 64'(d));
    @(negedge clk);
    check({tag, "/done_pulse"}, 64'(w8 ? done8 : done32), 64'd0);
    check({tag, "/busy_after"}, 64'(w8 ? busy8 : busy32), 64'd0);
    check({tag, "/hold"}, w8 ? {56'd0, res8} : {32'd0, res32}, r);
  endtask

  initial begin
    int lat, bcyc, first_k, second_k;
    bit seen_done;

    reset = 1'b1;
    start32 = 1'b0; ctl32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; ctl8  = '0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy", 64'(busy32), 64'd0);
    check("rst/done", 64'(done32), 64'd0);
    check("rst/result", {32'd0, res32}, 64'd0);
    check("rst/zero", 64'(zero32), 64'd0);
    check("rst8/result_hi", {56'd0, hi8}, 64'd0);
    reset = 1'b0;

    //  tag        w8 op       a             b             result        hi  c  z  o  d  lat
    vec("add32",   0, OP_ADD,  64'hFFFFFFFF, 64'h1,        64'h0,        0,  1, 1, 0, 0, 1);
    vec("sub32",   0, OP_SUB,  64'h80000000, 64'h1,        64'h7FFFFFFF, 0,  1, 0, 1, 0, 1);
    vec("subbr32", 0, OP_SUB,  64'h5,        64'h7,        64'hFFFFFFFE, 0,  0, 0, 0, 0, 1);
    vec("slt32",   0, OP_SLT,  64'hFFFFFFFF, 64'h1,        64'h1,        0,  0, 0, 0, 0, 1);
    vec("sltn32",  0, OP_SLT,  64'h1,        64'hFFFFFFFF, 64'h0,        0,  0, 1, 0, 0, 1);
    vec("and32",   0, OP_AND,  64'hC3C30000, 64'hFF00FF00, 64'hC3000000, 0,  0, 0, 0, 0, 1);
    vec("or32",    0, OP_OR,   64'h12340000, 64'h5678,     64'h12345678, 0,  0, 0, 0, 0, 1);
    vec("nor32",   0, OP_NOR,  64'h0F0F0F0F, 64'hF0F00000, 64'h0000F0F0, 0,  0, 0, 0, 0, 1);
    vec("mulu32",  0, OP_MULU, 64'hFFFFFFFF, 64'h2,        64'hFFFFFFFE, 1,  0, 0, 1, 0, 32);
    vec("divu32",  0, OP_DIVU, 64'd100,      64'd7,        64'd14,       2,  0, 0, 0, 0, 32);
    vec("div0_32", 0, OP_DIVU, 64'd5,        64'd0,        64'hFFFFFFFF, 5,  0, 0, 0, 1, 32);
    vec("rsv32",   0, 4'd9,    64'h12,       64'h34,       64'h0,        0,  0, 1, 0, 0, 1);
    vec("add8",    1, OP_ADD,  64'hFF,       64'h01,       64'h0,        0,  1, 1, 0, 0, 1);
    vec("sub8",    1, OP_SUB,  64'h80,       64'h01,       64'h7F,       0,  1, 0, 1, 0, 1);
    vec("slt8",    1, OP_SLT,  64'hFF,       64'h01,       64'h1,        0,  0, 0, 0, 0, 1);
    vec("mulu8",   1, OP_MULU, 64'hFF,       64'h02,       64'hFE,       1,  0, 0, 1, 0, 8);
    vec("mulsm8",  1, OP_MULU, 64'h0F,       64'h03,       64'h2D,       0,  0, 0, 0, 0, 8);
    vec("divu8",   1, OP_DIVU, 64'd100,      64'd7,        64'd14,       2,  0, 0, 0, 0, 8);
    vec("div0_8",  1, OP_DIVU, 64'd5,        64'd0,        64'hFF,       5,  0, 0, 0, 1, 8);

    // Start held high across a single-cycle op: dropped in the done cycle, accepted after.
    @(negedge clk);
    start32 = 1'b1; ctl32 = OP_ADD; a32 = 32'd1; b32 = 32'd1;
    @(posedge clk);
    first_k = -1;
    second_k = -1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (done32) begin
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
    end
    start32 = 1'b0;
    check("hold_start/first_done", 64'(first_k), 64'd1);
    check("hold_start/second_done", 64'(second_k), 64'd4);
    check("hold_start/result", {32'd0, res32}, 64'd2);
    repeat (3) @(negedge clk);

    // Abort a mulu with reset; a start during the op must be ignored.
    @(negedge clk);
    issue(0, OP_MULU, 64'hFFFFFFFF, 64'h2);
    seen_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done32) seen_done = 1'b1;
      start32 = (k == 5);
      ctl32   = OP_ADD;
      a32     = 32'd3;
      b32     = 32'd1;
      reset   = (k == 10);
      @(posedge clk);
      #1;
      start32 = 1'b0;
    end
    @(negedge clk);
    check("abort/no_done", 64'(seen_done | done32), 64'd0);
    check("abort/busy", 64'(busy32), 64'd0);
    check("abort/result", {32'd0, res32}, 64'd0);
    check("abort/result_hi", {32'd0, hi32}, 64'd0);
    check("abort/overflow", 64'(ovf32), 64'd0);
    check("abort/zero", 64'(zero32), 64'd0);
    reset = 1'b0;
    issue(0, OP_ADD, 64'd3, 64'd1);
    wait_done(0, lat, bcyc);
    check("post_rst/latency", 64'(lat), 64'd1);
    check("post_rst/result", {32'd0, res32}, 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32; operand/result width; legal values 8..64.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 control  input  4  opcode: 0 and, 1 or, 2 add, 3 sub, 4 slt, 5 nor, 6 mulu, 7 divu, 8-15 reserved.
REQ-006 a, b  input  WIDTH  operands; captured on accepted start.
REQ-007 busy  output  1  operation in flight; start ignored.
REQ-008 done  output  1  single-cycle pulse; all results valid that cycle.
REQ-009 result  output  WIDTH  low result / product low / quotient.
REQ-010 result_hi  output  WIDTH  product high / remainder; 0 for other ops.
REQ-011 cout, zero, overflow, div_by_zero  output  1 each  status flags.

Function
REQ-012 States IDLE, EXEC, ITER; IDLE->EXEC on start with opcode 0-5 or 8-15; IDLE->ITER on start with opcode 6-7; EXEC->IDLE after 1 cycle; ITER->IDLE after WIDTH cycles.
REQ-013 Start accepted at edge N: single-cycle ops assert done in cycle N+1; mulu/divu assert done in cycle N+WIDTH.
REQ-014 busy = 1 from cycle after acceptance through the done cycle inclusive; start with busy=1 dropped, no queueing.
REQ-015 Operands and opcode latched at acceptance; later input changes do not affect the operation in flight.
REQ-016 Outputs registered; hold last values from done until the next done.
REQ-017 add: result = a+b mod 2^WIDTH; cout = carry out; overflow = signed overflow.
REQ-018 sub: result = a-b mod 2^WIDTH; cout = 1 when a >= b unsigned (no borrow); overflow = signed overflow.
REQ-019 slt: result = 1 if a < b signed, else 0; cout = overflow = 0.
REQ-020 and/or/nor: bitwise; cout = overflow = 0.
REQ-021 mulu: unsigned shift-add, one bit per cycle; {result_hi,result} = a*b; overflow = (result_hi != 0); cout = 0.
REQ-022 divu: unsigned restoring, one bit per cycle; result = a/b, result_hi = a%b.
REQ-023 divu with b=0: result = all ones, result_hi = a, div_by_zero = 1, same latency; div_by_zero = 0 for every other case.
REQ-024 Reserved opcodes: result = result_hi = 0, all flags 0 except zero = 1, latency 1.
REQ-025 zero = (result == 0), low word only, every op.
REQ-026 Start coincident with done accepted only from cycle after done (busy still 1).

Reset
REQ-027 reset=1 at a clock edge: state IDLE; busy, done, result, result_hi, cout, overflow, div_by_zero = 0; zero = 0.
REQ-028 Reset mid-operation aborts it; no done pulse for the aborted op; start accepted on first edge with reset=0.
REQ-029 reset takes priority over start on the same edge.

Structure
REQ-030 Package alu_pkg holds opcode constants (OP_AND..OP_DIVU), state enumeration, and default WIDTH.
REQ-031 Iterative multiply/divide datapath in one sub-module muldiv_seq (WIDTH param, start/done, shared shift counter); single-cycle ops inline.

Verification
REQ-032 WIDTH=32, add 0xFFFFFFFF+0x00000001 -> result 0, cout 1, zero 1, overflow 0, done at N+1.
REQ-033 sub 0x80000000-0x00000001 -> result 0x7FFFFFFF, overflow 1, cout 1; slt 0xFFFFFFFF,0x00000001 -> result 1.
REQ-034 mulu 0xFFFFFFFF*0x00000002 -> result 0xFFFFFFFE, result_hi 1, overflow 1, done exactly at N+32, busy 1 for 32 cycles.
REQ-035 divu 100/7 -> result 14, result_hi 2; divu 5/0 -> result 0xFFFFFFFF, result_hi 5, div_by_zero 1.
REQ-036 start mulu, pulse start(add) at N+5, reset at N+10 -> second start ignored, no done, outputs 0; add 3+1 after reset -> result 4 at next cycle.
REQ-037 Repeat REQ-032..035 at WIDTH=8 (mulu 0xFF*0x02 -> result 0xFE, result_hi 1, done at N+8).
